fphub_align_add: RTL and testbench
==================================

Name: fphub_align_add

Overview:
- Pipelined stage directly downstream of the operand-ordering and exponent-difference stage of the FPHUB adder.
- Takes the ordered operands (larger-exponent mantissa Mx, smaller My, result exponent Ez, exponent distance).
- Appends the HUB implicit LSB (ILSB) to each mantissa, right-aligns My, and performs effective add or subtract.
- Emits an unnormalised magnitude, sign and exponent to the normalisation stage over a valid/ready handshake.

Parameters:
- M, 24, mantissa width including the leading 1 (form "1.M"); ILSB not included.
- E, 8, exponent width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream operand set valid.
- in_ready  out  1  this stage can accept an operand set.
- in_sx  in  1  sign of the larger-exponent operand.
- in_sy  in  1  sign of the smaller-exponent operand.
- in_mx  in  M  larger-exponent mantissa.
- in_my  in  M  smaller-exponent mantissa.
- in_ez  in  E  result exponent (the larger exponent).
- in_shamt  in  E  absolute exponent difference, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_mz  out  M+2  unnormalised magnitude; bit M+1 is the carry, ILSB position is bit 0.
- out_ez  out  E  exponent passed through.
- out_sz  out  1  result sign.
- out_zero  out  1  exact-zero result.

Behaviour:
- Two register stages, A (align) and B (add). Each stage has its own valid bit.
- Latency is 2 cycles from input acceptance to out_valid, with no stall. Throughput is 1 per cycle.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stall chain:
  - ready_B = !valid_B || out_ready.
  - ready_A = !valid_A || ready_B.
  - in_ready = ready_A, combinational from these terms.
- A stage holds its contents when not ready. A held value never changes.
- Stage A loads:
  - mx_ext = {in_mx, 1'b1}.
  - my_al = {in_my, 1'b1} >> in_shamt. If in_shamt >= M+1, my_al = 0.
  - Bits shifted out are discarded. HUB truncation is round-to-nearest, so there is no sticky bit.
  - eff_sub = in_sx ^ in_sy. Also loads in_sx and in_ez.
- Stage B:
  - If !eff_sub: mz = mx_ext + my_al, zero-extended to M+2 bits; sz = sx.
  - If eff_sub and mx_ext >= my_al: mz = mx_ext - my_al; sz = sx.
  - If eff_sub and mx_ext < my_al: mz = my_al - mx_ext; sz = !sx. This case is only possible at shamt = 0.
  - If mz == 0: out_zero = 1 and sz = 0 (+0).
- Reset values:
  - valid_A, valid_B, out_valid = 0.
  - out_mz = 0, out_ez = 0, out_sz = 0, out_zero = 0.
  - in_ready = 1 one cycle after reset deasserts. It stays 0 while rst is high.
- Reset mid-operation: all in-flight data is dropped. No output pulse occurs after reset.
- out_* payload is stable while out_valid && !out_ready.
- Simultaneous accept in and deliver out while full: both occur in the same cycle and ordering is preserved.
- Exponent special cases (zero/inf) are not handled here. They are flagged upstream.

Decomposition:
- Package fphub_pkg holds:
  - localparams for extended widths (MEXT = M+1, MSUM = M+2).
  - A typedef struct for the stage-A payload (mx_ext, my_al, sx, eff_sub, ez).
  - A typedef struct for the output payload (mz, ez, sz, zero).
- One sub-module: fphub_right_shifter (combinational barrel shifter, M+1 bits, saturating at shamt >= M+1), instantiated in stage A.

Test Plan:
- All cases use M=24, E=8.
- Same exponent, add: in_mx = in_my = 24'h800000, shamt 0, sx = sy = 0 -> 2 cycles later out_mz = 26'h2000002, sz = 0, zero = 0.
- Aligned add: in_mx = in_my = 24'h800000, shamt 1 -> out_mz = 26'h1800001. Repeat with shamt 30 -> my_al = 0, out_mz = 26'h1000001.
- Equal cancel: sx = 0, sy = 1, in_mx = in_my = 24'hA00000, shamt 0 -> out_mz = 0, out_zero = 1, out_sz = 0.
- Swap subtract: sx = 0, sy = 1, in_mx = 24'h800000, in_my = 24'hC00000, shamt 0 -> out_mz = 26'h0800000, out_sz = 1.
- Backpressure: push 4 distinct sets back-to-back with out_ready = 0 for 6 cycles:
  - in_ready drops after 2 accepts and out_valid holds the first result stable.
  - On releasing out_ready, all 4 results emerge in order with no loss or duplication.
- Reset mid-flight: assert rst with both stages valid -> out_valid = 0 immediately (asynchronous). After release, in_ready = 1 and no stale result appears.

Source files
------------

// File: rtl/fphub_pkg.sv
// fphub_pkg
//   Shared widths and payload types for the FPHUB adder align/add stage.
//   M    : mantissa width including the leading 1 (ILSB not included)
//   E    : exponent width
//   MEXT : mantissa width with the HUB implicit LSB appended
//   MSUM : adder result width (MEXT plus one carry bit)
package fphub_pkg;

  localparam int M    = 24;
  localparam int E    = 8;
  localparam int MEXT = M + 1;
  localparam int MSUM = M + 2;

  // Contents of the align register (stage A)
  typedef struct packed {
    logic [MEXT-1:0] mx_ext;
    logic [MEXT-1:0] my_al;
    logic            sx;
    logic            eff_sub;
    logic [E-1:0]    ez;
  } stage_a_t;

  // Contents of the add register (stage B), presented directly on out_*
  typedef struct packed {
    logic [MSUM-1:0] mz;
    logic [E-1:0]    ez;
    logic            sz;
    logic            zero;
  } out_t;

endpackage

// File: rtl/fphub_right_shifter.sv
// fphub_right_shifter
//   Combinational right shifter used to align the smaller-exponent mantissa.
//   Bits shifted past the LSB are discarded; any distance of W or more
//   produces all zeros.
//   din   : value to shift (W bits)
//   shamt : unsigned shift distance (SW bits)
//   dout  : din >> shamt, or 0 when shamt >= W
module fphub_right_shifter #(
  parameter int W  = 25,
  parameter int SW = 8
) (
  input  logic [W-1:0]  din,
  input  logic [SW-1:0] shamt,
  output logic [W-1:0]  dout
);

  logic [31:0] shamt_wide;

  // Compare in 32 bits so the saturation threshold never truncates
  assign shamt_wide = 32'(shamt);
  assign dout       = (shamt_wide >= 32'(W)) ? '0 : (din >> shamt);

endmodule

// File: rtl/fphub_align_add.sv
// fphub_align_add
//   Two-stage align/add pipeline of the FPHUB adder. Stage A appends the
//   HUB ILSB to both mantissas and right-aligns the smaller one; stage B
//   performs the effective add/subtract and produces an unnormalised
//   magnitude with sign, exponent and exact-zero flag.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : upstream handshake
//   in_sx, in_sy        : operand signs (larger / smaller exponent)
//   in_mx, in_my        : mantissas "1.M" (larger / smaller exponent)
//   in_ez               : result exponent
//   in_shamt            : exponent difference (unsigned)
//   out_valid/out_ready : downstream handshake
//   out_mz              : magnitude, bit M+1 carry, bit 0 at ILSB position
//   out_ez, out_sz      : exponent and sign of the result
//   out_zero            : result is exactly zero (reported as +0)
module fphub_align_add
  import fphub_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_sx,
  input  logic            in_sy,
  input  logic [M-1:0]    in_mx,
  input  logic [M-1:0]    in_my,
  input  logic [E-1:0]    in_ez,
  input  logic [E-1:0]    in_shamt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [MSUM-1:0] out_mz,
  output logic [E-1:0]    out_ez,
  output logic            out_sz,
  output logic            out_zero
);

  logic            valid_a;
  logic            valid_b;
  logic            ready_a;
  logic            ready_b;
  logic            init_done;
  stage_a_t        stage_a;
  out_t            stage_b;
  out_t            sum_next;
  logic [MEXT-1:0] my_shifted;
  logic [MSUM-1:0] mx_w;
  logic [MSUM-1:0] my_w;

  fphub_right_shifter #(
    .W  (MEXT),
    .SW (E)
  ) u_shifter (
    .din   ({in_my, 1'b1}),
    .shamt (in_shamt),
    .dout  (my_shifted)
  );

  // Stall chain: a stage may load when empty or when its successor drains
  assign ready_b  = !valid_b || out_ready;
  assign ready_a  = !valid_a || ready_b;
  assign in_ready = init_done && ready_a;

  // Holds in_ready low during reset and for the first cycle after release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
    end
  end

  // Stage A: capture extended and aligned mantissas on an input transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_a <= 1'b0;
      stage_a <= '0;
    end else if (in_ready) begin
      valid_a <= in_valid;
      if (in_valid) begin
        stage_a.mx_ext  <= {in_mx, 1'b1};
        stage_a.my_al   <= my_shifted;
        stage_a.sx      <= in_sx;
        stage_a.eff_sub <= in_sx ^ in_sy;
        stage_a.ez      <= in_ez;
      end
    end
  end

  // Effective add/subtract; a negative difference (only possible at equal
  // exponents) is turned into a magnitude with the sign flipped
  always_comb begin
    mx_w        = {1'b0, stage_a.mx_ext};
    my_w        = {1'b0, stage_a.my_al};
    sum_next    = '0;
    sum_next.ez = stage_a.ez;
    if (!stage_a.eff_sub) begin
      sum_next.mz = mx_w + my_w;
      sum_next.sz = stage_a.sx;
    end else if (mx_w >= my_w) begin
      sum_next.mz = mx_w - my_w;
      sum_next.sz = stage_a.sx;
    end else begin
      sum_next.mz = my_w - mx_w;
      sum_next.sz = !stage_a.sx;
    end
    sum_next.zero = (sum_next.mz == '0);
    if (sum_next.zero) begin
      sum_next.sz = 1'b0;
    end
  end

  // Stage B: the payload only changes when a new stage-A result moves in,
  // so a stalled output stays stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_b <= 1'b0;
      stage_b <= '0;
    end else if (ready_b) begin
      valid_b <= valid_a;
      if (valid_a) begin
        stage_b <= sum_next;
      end
    end
  end

  assign out_valid = valid_b;
  assign out_mz    = stage_b.mz;
  assign out_ez    = stage_b.ez;
  assign out_sz    = stage_b.sz;
  assign out_zero  = stage_b.zero;

endmodule

// File: tb/tb_fphub_align_add.sv
// tb_fphub_align_add
//   Directed, table-driven bench for fphub_align_add (M=24, E=8), plus
//   hand-written backpressure and reset-mid-flight sequences.
module tb_fphub_align_add;

  typedef struct {
    logic        sx;
    logic        sy;
    logic [23:0] mx;
    logic [23:0] my;
    logic [7:0]  ez;
    logic [7:0]  shamt;
    logic [25:0] mz;
    logic        sz;
    logic        zero;
  } vec_t;

  localparam int NVEC = 12;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sx;
  logic        in_sy;
  logic [23:0] in_mx;
  logic [23:0] in_my;
  logic [7:0]  in_ez;
  logic [7:0]  in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] out_mz;
  logic [7:0]  out_ez;
  logic        out_sz;
  logic        out_zero;

  int checks;
  int errors;
  vec_t vecs [NVEC];

  fphub_align_add dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sx     (in_sx),
    .in_sy     (in_sy),
    .in_mx     (in_mx),
    .in_my     (in_my),
    .in_ez     (in_ez),
    .in_shamt  (in_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mz    (out_mz),
    .out_ez    (out_ez),
    .out_sz    (out_sz),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operand set onto the input port
  task automatic applyStimulus(input vec_t v, input logic valid);
    in_valid = valid;
    in_sx    = v.sx;
    in_sy    = v.sy;
    in_mx    = v.mx;
    in_my    = v.my;
    in_ez    = v.ez;
    in_shamt = v.shamt;
  endtask

  // Single comparison point: counts and reports every check
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] expPayload(input vec_t v);
    return 64'({1'b1, v.mz, v.ez, v.sz, v.zero});
  endfunction

  function automatic logic [63:0] actPayload();
    return 64'({out_valid, out_mz, out_ez, out_sz, out_zero});
  endfunction

  initial begin
    int in_idx;
    int out_idx;
    int cyc;
    logic acc_in;
    logic acc_out;
    int bp_sel [4];

    checks = 0;
    errors = 0;

    //          sx    sy    mx          my          ez     shamt  mz            sz    zero
    vecs[0]  = '{1'b0, 1'b0, 24'h800000, 24'h800000, 8'h7F, 8'd0,   26'h2000002, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 24'h800000, 24'h800000, 8'h80, 8'd1,   26'h1800001, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 24'h800000, 24'h800000, 8'h81, 8'd30,  26'h1000001, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 24'hA00000, 24'hA00000, 8'h10, 8'd0,   26'h0000000, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 24'h800000, 24'hC00000, 8'h20, 8'd0,   26'h0800000, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 24'hFFFFFF, 24'hFFFFFF, 8'hFE, 8'd0,   26'h3FFFFFE, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 24'h800000, 24'hFFFFFF, 8'h05, 8'd1,   26'h0000002, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 24'hC00000, 24'h800000, 8'h44, 8'd2,   26'h1400001, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 24'h800000, 24'h800000, 8'h01, 8'd24,  26'h1000002, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 24'h800000, 24'h800000, 8'h02, 8'd25,  26'h1000001, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 24'h800000, 24'h800000, 8'h03, 8'hFF,  26'h1000001, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 24'hA00000, 24'hA00000, 8'h66, 8'd0,   26'h0000000, 1'b0, 1'b1};

    // Reset state
    rst       = 1'b1;
    out_ready = 1'b1;
    applyStimulus(vecs[0], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset_payload", 64'({out_mz, out_ez, out_sz, out_zero}), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("in_ready_before_first_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Table vectors, one at a time, checking the 2-cycle latency
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d", i), actPayload(), expPayload(vecs[i]));
      @(posedge clk);
      #1;
    end

    // Backpressure: four sets back-to-back, output blocked for six cycles
    bp_sel[0] = 0;
    bp_sel[1] = 4;
    bp_sel[2] = 6;
    bp_sel[3] = 8;
    in_idx  = 0;
    out_idx = 0;
    cyc     = 0;
    while (out_idx < 4 && cyc < 40) begin
      out_ready = (cyc >= 6);
      if (in_idx < 4) applyStimulus(vecs[bp_sel[in_idx]], 1'b1);
      else            in_valid = 1'b0;
      #1;
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (out_valid) begin
        checkOutput($sformatf("bp_out%0d_cyc%0d", out_idx, cyc), actPayload(), expPayload(vecs[bp_sel[out_idx]]));
      end
      if (cyc == 5) begin
        checkOutput("bp_accepts_before_stall", 64'(in_idx), 64'd2);
        checkOutput("bp_in_ready_stalled", 64'(in_ready), 64'd0);
        checkOutput("bp_out_valid_stalled", 64'(out_valid), 64'd1);
      end
      @(posedge clk);
      #1;
      if (acc_in)  in_idx++;
      if (acc_out) out_idx++;
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput("bp_all_delivered", 64'(out_idx), 64'd4);
    checkOutput("bp_all_accepted", 64'(in_idx), 64'd4);
    repeat (3) begin
      checkOutput("bp_no_duplicate", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end

    // Reset mid-flight with both stages holding data
    out_ready = 1'b0;
    applyStimulus(vecs[1], 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(vecs[5], 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("midreset_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset_out_valid_async", 64'(out_valid), 64'd0);
    checkOutput("midreset_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset_in_ready_after", 64'(in_ready), 64'd1);
    repeat (5) begin
      checkOutput("midreset_no_stale", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
